// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux
// Four-digit time-multiplexed scan driver for a seven-segment decoder.
// A 16-bit hex value is held in a display register and one nibble per scan
// slot is presented on digit_data with the matching active-low digit enable.
// New values are captured into a pending buffer and only committed at a frame
// boundary (slot 3 -> slot 0), so a frame never mixes two values.
// Optional leading-zero blanking disables digits 3..1 while they and all
// higher digits are zero.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   load       in   1   strobe: capture value_in into the pending buffer
//   value_in   in  16   hex value, nibble k drives digit k
//   blank_lz   in   1   1 = blank leading zero digits 3..1 (sampled at tick)
//   digit_data out  4   nibble of the current digit (to decoder data_in)
//   digit_sel  out  4   active-low digit enables, at most one bit low
//   load_ack   out  1   one-cycle pulse when pending is committed
// ---------------------------------------------------------------------------
module display_scan_mux #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    output logic [3:0]  digit_data,
    output logic [3:0]  digit_sel,
    output logic        load_ack
);

    // A single-cycle slot still needs a one-bit prescaler to exist.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LP_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pending;
    logic          r_pending_valid;
    logic [3:0]    r_digit_data;
    logic [3:0]    r_digit_sel;
    logic          r_load_ack;

    logic          w_tick;
    logic          w_commit;
    logic [1:0]    w_idx_next;
    logic [15:0]   w_disp_next;
    logic [3:0]    w_nibble;
    logic [3:0]    w_sel_next;

    // Nibble n of a 16-bit value.
    function automatic logic [3:0] nibble_of(input logic [15:0] value, input logic [1:0] n);
        logic [3:0] nib;
        case (n)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            2'd3:    nib = value[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Digit n is a leading zero when it and every higher nibble are zero;
    // digit 0 always stays visible so a zero value still shows "0".
    function automatic logic is_leading_zero(input logic [15:0] value, input logic [1:0] n);
        logic lz;
        case (n)
            2'd1:    lz = (value[15:4]  == 12'h000);
            2'd2:    lz = (value[15:8]  == 8'h00);
            2'd3:    lz = (value[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

    // Slot tick, frame-boundary commit and next-slot output values.
    always_comb begin
        w_tick      = (r_presc == LP_LAST);
        w_idx_next  = r_idx + 2'd1;
        // Boundary is the tick that wraps idx from 3 back to 0.
        w_commit    = w_tick && (r_idx == 2'd3) && r_pending_valid;
        if (w_commit) begin
            w_disp_next = r_pending;
        end else begin
            w_disp_next = r_disp;
        end
        w_nibble = nibble_of(w_disp_next, w_idx_next);
        if (blank_lz && is_leading_zero(w_disp_next, w_idx_next)) begin
            w_sel_next = 4'b1111;
        end else begin
            w_sel_next = ~(4'b0001 << w_idx_next);
        end
    end

    // Prescaler and scan index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= w_idx_next;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Pending buffer and display register; a load on the commit edge
    // becomes the new pending value while the old one is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= 16'h0000;
            r_pending_valid <= 1'b0;
            r_disp          <= 16'h0000;
        end else begin
            r_disp <= w_disp_next;
            if (load) begin
                r_pending       <= value_in;
                r_pending_valid <= 1'b1;
            end else if (w_commit) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    // Registered outputs: digit data/enable change only on tick, ack pulses on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_data <= 4'h0;
            r_digit_sel  <= 4'b1111;
            r_load_ack   <= 1'b0;
        end else begin
            r_load_ack <= w_commit;
            if (w_tick) begin
                r_digit_data <= w_nibble;
                r_digit_sel  <= w_sel_next;
            end
        end
    end

    assign digit_data = r_digit_data;
    assign digit_sel  = r_digit_sel;
    assign load_ack   = r_load_ack;

endmodule
